ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage for the MIPS datapath. It sits directly upstream of the ALU and drives its entradaA, entradaB and entradaControl inputs. It captures decoded instruction fields each cycle, resolves data hazards by forwarding from EX/MEM and MEM/WB, and supports stall, flush and load-use hazard detection.

---
 rtl/ex_operand_stage.sv | 120 ++++++++++++
 tb/tb_ex_operand_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Feeds ALU operands and control and raises the load-use stall request.
module ex_operand_stage #(
    parameter int WIDTH      = 32,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic [3:0]       id_alu_control,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] entradaA,
    output logic [WIDTH-1:0] entradaB,
    output logic [3:0]       entradaControl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [4:0]       ex_dest,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             load_use_hazard
);

    logic             alu_src_q;
    logic [3:0]       alu_control_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [WIDTH-1:0] rs_data_q;
    logic [WIDTH-1:0] rt_data_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    // EX/MEM beats MEM/WB; register zero is hard-wired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        if (FORWARD_EN) begin
            if (rs_q != 5'd0) begin
                if (exmem_reg_write && (exmem_rd == rs_q))
                    fwd_rs = exmem_result;
                else if (memwb_reg_write && (memwb_rd == rs_q))
                    fwd_rs = memwb_result;
            end
            if (rt_q != 5'd0) begin
                if (exmem_reg_write && (exmem_rd == rt_q))
                    fwd_rt = exmem_result;
                else if (memwb_reg_write && (memwb_rd == rt_q))
                    fwd_rt = memwb_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            alu_src_q     <= 1'b0;
            alu_control_q <= 4'd0;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            ex_dest       <= 5'd0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
        end else if (stall) begin
            // Re-capture forwarded operands so a value retiring from MEM/WB
            // during a long stall is not lost.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
            alu_src_q     <= id_alu_src;
            alu_control_q <= id_alu_control;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            ex_dest       <= id_reg_dst ? id_rd : id_rt;
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
        end
    end

    assign entradaA       = fwd_rs;
    assign entradaB       = alu_src_q ? imm_q : fwd_rt;
    assign entradaControl = alu_control_q;
    assign ex_store_data  = fwd_rt;

    // The rt compare is deliberately conservative (fires even for I-type rt).
    assign load_use_hazard = ~reset & ex_valid & ex_mem_read & (ex_dest != 5'd0)
                           & id_valid & ((id_rs == ex_dest) | (id_rt == ex_dest));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: instruction-level reference model with
// a per-cycle compare process plus hand-computed spot checks.
module tb_ex_operand_stage;

    localparam int W = 32;

    logic         clk;
    logic         reset, stall, flush;
    logic         id_valid;
    logic [W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]   id_rs, id_rt, id_rd;
    logic         id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [3:0]   id_alu_control;
    logic         exmem_reg_write;
    logic [4:0]   exmem_rd;
    logic [W-1:0] exmem_result;
    logic         memwb_reg_write;
    logic [4:0]   memwb_rd;
    logic [W-1:0] memwb_result;
    logic [W-1:0] entradaA, entradaB, ex_store_data;
    logic [3:0]   entradaControl;
    logic [4:0]   ex_dest;
    logic         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic         load_use_hazard;

    int tests_run = 0;
    int tests_failed = 0;

    ex_operand_stage #(.WIDTH(W), .FORWARD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_control(id_alu_control),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .entradaA(entradaA), .entradaB(entradaB), .entradaControl(entradaControl),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // One in-flight instruction: what sits in EX and what values it carries.
    typedef struct {
        logic         v, rw, mr, mw, m2r, use_imm;
        logic [3:0]   op;
        logic [4:0]   src_a, src_b, dst;
        logic [W-1:0] val_a, val_b, imm;
    } instr_t;

    instr_t ex_ins;
    bit     model_ok = 0;

    function automatic logic [W-1:0] operand(input logic [4:0] src, input logic [W-1:0] held);
        if (src == 0) return held;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return held;
    endfunction

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.m2r = 0; b.use_imm = 0;
        b.op = 0; b.src_a = 0; b.src_b = 0; b.dst = 0;
        b.val_a = 0; b.val_b = 0; b.imm = 0;
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset || flush) begin
            ex_ins = bubble();
        end else if (stall) begin
            ex_ins.val_a = operand(ex_ins.src_a, ex_ins.val_a);
            ex_ins.val_b = operand(ex_ins.src_b, ex_ins.val_b);
        end else begin
            ex_ins.v = id_valid;
            ex_ins.rw = id_valid && id_reg_write;
            ex_ins.mr = id_valid && id_mem_read;
            ex_ins.mw = id_valid && id_mem_write;
            ex_ins.m2r = id_valid && id_mem_to_reg;
            ex_ins.use_imm = id_alu_src;
            ex_ins.op = id_alu_control;
            ex_ins.src_a = id_rs;
            ex_ins.src_b = id_rt;
            ex_ins.dst = id_reg_dst ? id_rd : id_rt;
            ex_ins.val_a = id_rs_data;
            ex_ins.val_b = id_rt_data;
            ex_ins.imm = id_imm;
        end
        if (reset) model_ok = 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            logic [W-1:0] a, b;
            logic hz;
            a = operand(ex_ins.src_a, ex_ins.val_a);
            b = operand(ex_ins.src_b, ex_ins.val_b);
            hz = !reset && ex_ins.v && ex_ins.mr && ex_ins.dst != 0 && id_valid
                 && (id_rs == ex_ins.dst || id_rt == ex_ins.dst);
            check("model_entradaA", entradaA, a);
            check("model_entradaB", entradaB, ex_ins.use_imm ? ex_ins.imm : b);
            check("model_store_data", ex_store_data, b);
            check("model_control", W'(entradaControl), W'(ex_ins.op));
            check("model_dest", W'(ex_dest), W'(ex_ins.dst));
            check("model_ctrl_bits", W'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                  W'({ex_ins.v, ex_ins.rw, ex_ins.mr, ex_ins.mw, ex_ins.m2r}));
            check("model_load_use", W'(load_use_hazard), W'(hz));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_alu_control = 0;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; stall = 0; flush = 0;
        clear_fwd();
        id_valid = 1; id_rs_data = 32'h1234; id_rt_data = 32'h5678; id_imm = 32'h9;
        id_rs = 5'd4; id_rt = 5'd5; id_rd = 5'd6; id_alu_src = 1; id_reg_dst = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_mem_to_reg = 1;
        id_alu_control = 4'd7;

        // Reset held two cycles with busy ID inputs.
        step();
        step();
        #2;
        check("reset_entradaA", entradaA, 0);
        check("reset_entradaB", entradaB, 0);
        check("reset_control", W'(entradaControl), 0);
        check("reset_dest", W'(ex_dest), 0);
        check("reset_valid", W'(ex_valid), 0);
        check("reset_hazard", W'(load_use_hazard), 0);

        // Release: first captured instruction appears one cycle later.
        reset = 0;
        clear_id();
        id_valid = 1; id_rs = 5'd1; id_rs_data = 32'd5; id_imm = 32'd7;
        id_alu_src = 1; id_alu_control = 4'd2;
        step();
        #2;
        check("release_entradaA", entradaA, 32'd5);
        check("release_entradaB", entradaB, 32'd7);
        check("release_control", W'(entradaControl), 32'd2);

        // Forward priority on rs=3.
        clear_id();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'd1; id_alu_control = 4'd2;
        step();
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #2;
        check("fwd_exmem_wins", entradaA, 32'hAA);
        exmem_reg_write = 0;
        #2;
        check("fwd_memwb", entradaA, 32'hBB);
        clear_fwd();
        #1;
        check("fwd_none", entradaA, 32'd1);

        // Register zero is never forwarded.
        clear_id();
        id_valid = 1; id_rs = 5'd0; id_rs_data = 32'd0;
        step();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF;
        #2;
        check("reg_zero_no_fwd", entradaA, 32'd0);
        clear_fwd();

        // Stall refresh: MEM/WB value on rt seen only in the first stall cycle.
        clear_id();
        id_valid = 1; id_rt = 5'd9; id_rt_data = 32'h11; id_rd = 5'd10;
        id_reg_dst = 1; id_reg_write = 1; id_alu_control = 4'd6;
        step();
        stall = 1;
        memwb_reg_write = 1; memwb_rd = 5'd9; memwb_result = 32'h55;
        id_rt = 5'd4; id_rt_data = 32'h99; id_alu_control = 4'd12; id_mem_read = 1;
        #2;
        check("stall_c1_B", entradaB, 32'h55);
        step();
        memwb_reg_write = 0; memwb_result = 32'h0;
        for (int c = 2; c <= 3; c++) begin
            #2;
            check("stall_hold_B", entradaB, 32'h55);
            check("stall_hold_ctrl", W'(entradaControl), 32'd6);
            check("stall_hold_rw", W'(ex_reg_write), 32'd1);
            check("stall_hold_dest", W'(ex_dest), 32'd10);
            step();
        end
        stall = 0;

        // Flush and stall together with a valid sw in ID.
        clear_id();
        id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_alu_control = 4'd2;
        id_imm = 32'h4; id_rs = 5'd2; id_rt = 5'd3;
        flush = 1; stall = 1;
        step();
        #2;
        check("flush_valid", W'(ex_valid), 0);
        check("flush_mem_write", W'(ex_mem_write), 0);
        check("flush_control", W'(entradaControl), 0);
        flush = 0; stall = 0;

        // Load-use: lw writing r8, then consumer reading r8 via rt.
        clear_id();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
        id_alu_src = 1; id_rt = 5'd8; id_rs = 5'd1; id_alu_control = 4'd2;
        step();
        clear_id();
        id_valid = 1; id_rs = 5'd2; id_rt = 5'd8; id_reg_dst = 1; id_rd = 5'd9;
        #2;
        check("load_use_rt", W'(load_use_hazard), 1);
        id_valid = 0;
        #1;
        check("load_use_id_invalid", W'(load_use_hazard), 0);

        // lw into r0 never raises the hazard.
        clear_id();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_alu_src = 1; id_rt = 5'd0;
        step();
        clear_id();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        #2;
        check("load_use_dest0", W'(load_use_hazard), 0);

        // Reset in the middle of a stall clears everything.
        clear_id();
        id_valid = 1; id_rs = 5'd7; id_rs_data = 32'h77; id_reg_write = 1; id_alu_control = 4'd1;
        step();
        stall = 1;
        step();
        reset = 1;
        step();
        reset = 0; stall = 0;
        clear_id();
        #2;
        check("reset_mid_stall_A", entradaA, 0);
        check("reset_mid_stall_rw", W'(ex_reg_write), 0);

        // A few back-to-back instructions for the per-cycle compare.
        for (int i = 0; i < 6; i++) begin
            id_valid = 1;
            id_rs = 5'(i + 1); id_rt = 5'(i + 2); id_rd = 5'(i + 3);
            id_rs_data = 32'h100 + i; id_rt_data = 32'h200 + i; id_imm = 32'h300 + i;
            id_alu_src = i[0]; id_reg_dst = i[1]; id_reg_write = 1;
            id_alu_control = (i % 2 == 0) ? 4'd2 : 4'd6;
            exmem_reg_write = 1; exmem_rd = 5'(i); exmem_result = 32'hE00 + i;
            memwb_reg_write = 1; memwb_rd = 5'(i + 1); memwb_result = 32'hD00 + i;
            step();
        end
        clear_fwd();
        clear_id();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
